// File: rtl/header_rewriter_if.sv
// NetFPGA word stream between pipeline stages: data/ctrl/wr travel forward, rdy travels back.
interface header_rewriter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] data;
    logic [CTRL_WIDTH-1:0] ctrl;
    logic                  wr;
    logic                  rdy;

    modport master (output data, ctrl, wr, input rdy);
    modport slave  (input data, ctrl, wr, output rdy);
endinterface

// File: rtl/header_rewriter.sv
// Applies one OpenFlow modify-field action per packet to L2/L3/L4 header fields
// and patches the IPv4 header checksum incrementally (RFC 1624).
module header_rewriter #(
    parameter int                    DATA_WIDTH = 64,
    parameter int                    CTRL_WIDTH = DATA_WIDTH / 8,
    parameter logic [CTRL_WIDTH-1:0] IOQ_CTRL   = 8'hFF
) (
    input  logic                     clk,
    input  logic                     reset,
    header_rewriter_if.slave         in_s,
    header_rewriter_if.master        out_s,
    input  logic                     act_valid,
    output logic                     act_rdy,
    input  logic [7:0]               act_mask,
    input  logic [47:0]              act_dl_dst,
    input  logic [47:0]              act_dl_src,
    input  logic [31:0]              act_nw_src,
    input  logic [31:0]              act_nw_dst,
    input  logic [7:0]               act_nw_tos,
    input  logic [15:0]              act_tp_src,
    input  logic [15:0]              act_tp_dst,
    output logic [31:0]              pkts_modified
);

    // Wn means "the next ctrl==0 word accepted is word n"; MOD_HDR also takes W0.
    typedef enum logic [3:0] {
        WAIT_ACT, MOD_HDR, W1, W2, W3, W4, DRAIN, PAYLOAD
    } state_t;

    state_t                  state;
    logic [6:0]              m;
    logic [47:0]             a_dl_dst, a_dl_src;
    logic [31:0]             a_nw_src, a_nw_dst;
    logic [7:0]              a_tos;
    logic [15:0]             a_tp_src, a_tp_dst;

    logic                    is_ip, nofrag, pkt_mod, hold_eop;
    logic [3:0]              ihl;
    logic [7:0]              proto;
    logic [15:0]             old_vt, old_hc, old_dst_hi;
    logic [31:0]             old_src;
    logic [DATA_WIDTH-1:0]   hold_data;
    logic [CTRL_WIDTH-1:0]   hold_ctrl;

    logic [DATA_WIDTH-1:0]   out_data_r;
    logic [CTRL_WIDTH-1:0]   out_ctrl_r;
    logic                    out_wr_r;
    logic [31:0]             cnt;

    logic                    accept, eop, w1_ip, tp_ok, chg;
    logic [DATA_WIDTH-1:0]   rw;
    logic [15:0]             new_vt, new_hc, fold2;
    logic [16:0]             fold1;
    logic [19:0]             acc;

    logic unused_bits;
    assign unused_bits = ^{act_mask[7], IOQ_CTRL};

    assign in_s.rdy   = out_s.rdy && (state != WAIT_ACT) && (state != DRAIN);
    assign act_rdy    = (state == WAIT_ACT);
    assign accept     = in_s.wr && in_s.rdy;
    assign eop        = (in_s.ctrl != '0);
    assign out_s.data = out_data_r;
    assign out_s.ctrl = out_ctrl_r;
    assign out_s.wr   = out_wr_r;
    assign pkts_modified = cnt;

    assign w1_ip = (in_s.data[31:16] == 16'h0800) && (in_s.data[15:12] == 4'd4);
    assign tp_ok = is_ip && (ihl == 4'd5) && nofrag && (proto == 8'd6 || proto == 8'd17);

    function automatic logic [19:0] ext(input logic [15:0] v);
        return {4'b0, v};
    endfunction

    // Field substitution for the word currently on the input, by position.
    always_comb begin
        rw = in_s.data;
        case (state)
            MOD_HDR: if (!eop) begin
                if (m[0]) rw[63:16] = a_dl_dst;
                if (m[1]) rw[15:0]  = a_dl_src[47:32];
            end
            W1: begin
                if (m[1])          rw[63:32] = a_dl_src[31:0];
                if (w1_ip && m[4]) rw[7:0]   = a_tos;
            end
            W3: if (is_ip) begin
                if (m[2]) rw[47:16] = a_nw_src;
                if (m[3]) rw[15:0]  = a_nw_dst[31:16];
            end
            W4: begin
                if (is_ip && m[3]) rw[63:48] = a_nw_dst[15:0];
                if (tp_ok) begin
                    if (m[5]) rw[47:32] = a_tp_src;
                    if (m[6]) rw[31:16] = a_tp_dst;
                end
            end
            default: ;
        endcase
    end

    // HC' = ~(~HC + sum(~m + m')) over the 16-bit header words this action changes.
    // Evaluated while W4 is on the input, whose [63:48] is the old nw_dst low half.
    always_comb begin
        new_vt = {old_vt[15:8], m[4] ? a_tos : old_vt[7:0]};
        acc    = ext(~old_hc);
        if (is_ip) begin
            if (m[4]) acc = acc + ext(~old_vt) + ext(new_vt);
            if (m[2]) acc = acc + ext(~old_src[31:16]) + ext(a_nw_src[31:16])
                                + ext(~old_src[15:0])  + ext(a_nw_src[15:0]);
            if (m[3]) acc = acc + ext(~old_dst_hi)        + ext(a_nw_dst[31:16])
                                + ext(~in_s.data[63:48])  + ext(a_nw_dst[15:0]);
        end
        fold1  = {1'b0, acc[15:0]} + {13'b0, acc[19:16]};
        fold2  = fold1[15:0] + {15'b0, fold1[16]};
        new_hc = ~fold2;
    end

    assign chg = (rw != in_s.data) || (state == W4 && !eop && new_hc != old_hc);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= WAIT_ACT;
            m          <= '0;
            a_dl_dst   <= '0;
            a_dl_src   <= '0;
            a_nw_src   <= '0;
            a_nw_dst   <= '0;
            a_tos      <= '0;
            a_tp_src   <= '0;
            a_tp_dst   <= '0;
            is_ip      <= 1'b0;
            nofrag     <= 1'b0;
            pkt_mod    <= 1'b0;
            hold_eop   <= 1'b0;
            ihl        <= '0;
            proto      <= '0;
            old_vt     <= '0;
            old_hc     <= '0;
            old_dst_hi <= '0;
            old_src    <= '0;
            hold_data  <= '0;
            hold_ctrl  <= '0;
            out_data_r <= '0;
            out_ctrl_r <= '0;
            out_wr_r   <= 1'b0;
            cnt        <= '0;
        end else begin
            out_wr_r <= 1'b0;
            case (state)
                WAIT_ACT: if (act_valid) begin
                    m        <= act_mask[6:0];
                    a_dl_dst <= act_dl_dst;
                    a_dl_src <= act_dl_src;
                    a_nw_src <= act_nw_src;
                    a_nw_dst <= act_nw_dst;
                    a_tos    <= act_nw_tos;
                    a_tp_src <= act_tp_src;
                    a_tp_dst <= act_tp_dst;
                    is_ip    <= 1'b0;
                    nofrag   <= 1'b0;
                    pkt_mod  <= 1'b0;
                    state    <= MOD_HDR;
                end
                DRAIN: if (out_s.rdy) begin
                    out_wr_r   <= 1'b1;
                    out_data_r <= hold_data;
                    out_ctrl_r <= hold_ctrl;
                    state      <= hold_eop ? WAIT_ACT : PAYLOAD;
                end
                default: if (accept) begin
                    out_wr_r   <= 1'b1;
                    out_data_r <= rw;
                    out_ctrl_r <= in_s.ctrl;
                    if (chg) pkt_mod <= 1'b1;
                    case (state)
                        MOD_HDR: if (!eop) state <= W1;
                        W1: begin
                            is_ip  <= w1_ip;
                            ihl    <= in_s.data[11:8];
                            old_vt <= in_s.data[15:0];
                            state  <= W2;
                        end
                        W2: begin
                            proto  <= in_s.data[7:0];
                            nofrag <= (in_s.data[28:16] == 13'd0) && !in_s.data[29];
                            state  <= W3;
                        end
                        W3: if (!eop) begin
                            // W3 waits for W4 so its checksum can cover the nw_dst low half.
                            out_wr_r   <= 1'b0;
                            hold_data  <= rw;
                            old_hc     <= in_s.data[63:48];
                            old_src    <= in_s.data[47:16];
                            old_dst_hi <= in_s.data[15:0];
                            state      <= W4;
                        end
                        W4: begin
                            out_data_r <= eop ? hold_data : {new_hc, hold_data[47:0]};
                            out_ctrl_r <= '0;
                            hold_data  <= rw;
                            hold_ctrl  <= in_s.ctrl;
                            hold_eop   <= eop;
                            state      <= DRAIN;
                        end
                        default: ;
                    endcase
                    if (eop && state != MOD_HDR && state != W4) state <= WAIT_ACT;
                    if (eop && state != MOD_HDR && (pkt_mod || chg)) cnt <= cnt + 32'd1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_header_rewriter.sv
// Directed checks of header_rewriter: field rewrites, checksum patching, gating and flow control.
module tb_header_rewriter;
    logic        clk = 1'b0;
    logic        reset;
    logic        act_valid, act_rdy;
    logic [7:0]  act_mask, act_nw_tos;
    logic [47:0] act_dl_dst, act_dl_src;
    logic [31:0] act_nw_src, act_nw_dst, pkts_modified;
    logic [15:0] act_tp_src, act_tp_dst;
    logic        tog_en = 1'b0;

    int n_asrt = 0;
    int n_fail = 0;

    logic [63:0] pd[7];
    logic [63:0] ed[7];
    logic [7:0]  pc[7];
    logic [63:0] oq_d[$];
    logic [7:0]  oq_c[$];

    always #5 clk = ~clk;

    header_rewriter_if in_if ();
    header_rewriter_if out_if ();

    header_rewriter dut (
        .clk(clk), .reset(reset), .in_s(in_if), .out_s(out_if),
        .act_valid(act_valid), .act_rdy(act_rdy), .act_mask(act_mask),
        .act_dl_dst(act_dl_dst), .act_dl_src(act_dl_src),
        .act_nw_src(act_nw_src), .act_nw_dst(act_nw_dst), .act_nw_tos(act_nw_tos),
        .act_tp_src(act_tp_src), .act_tp_dst(act_tp_dst),
        .pkts_modified(pkts_modified)
    );

    always @(negedge clk) out_if.rdy = tog_en ? ~out_if.rdy : 1'b1;

    always @(negedge clk) if (out_if.wr) begin
        oq_d.push_back(out_if.data);
        oq_c.push_back(out_if.ctrl);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] full_csum(input logic [63:0] w1, w2, w3, w4);
        logic [19:0] s;
        s = {4'b0, w1[15:0]} + {4'b0, w2[63:48]} + {4'b0, w2[47:32]} + {4'b0, w2[31:16]}
          + {4'b0, w2[15:0]} + {4'b0, w3[47:32]} + {4'b0, w3[31:16]} + {4'b0, w3[15:0]}
          + {4'b0, w4[63:48]};
        s = {4'b0, s[15:0]} + {16'b0, s[19:16]};
        s = {4'b0, s[15:0]} + {16'b0, s[19:16]};
        return ~s[15:0];
    endfunction

    task automatic give_act(input logic [7:0] mask);
        bit ok = 1'b0;
        act_mask  = mask;
        act_valid = 1'b1;
        for (int t = 0; t < 200 && !ok; t++) begin
            #1 ok = act_rdy;
            @(negedge clk);
        end
        act_valid = 1'b0;
        chk("act_accept", ok, 1);
    endtask

    task automatic send(input int i);
        bit ok = 1'b0;
        in_if.data = pd[i];
        in_if.ctrl = pc[i];
        in_if.wr   = 1'b1;
        for (int t = 0; t < 200 && !ok; t++) begin
            #1 ok = in_if.rdy;
            @(negedge clk);
        end
        in_if.wr = 1'b0;
        chk($sformatf("accept_w%0d", i), ok, 1);
    endtask

    // Sends words lo..hi; after a non-EOP W4 the stage must be draining.
    task automatic send_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            send(i);
            if (i == 5 && pc[5] == 8'h00) #1 chk("drain_in_rdy", in_if.rdy, 0);
        end
    endtask

    task automatic check_out(input string name);
        repeat (12) @(negedge clk);
        chk({name, "_count"}, oq_d.size(), 7);
        for (int i = 0; i < 7 && i < oq_d.size(); i++) begin
            chk($sformatf("%s_w%0d", name, i), oq_d[i], ed[i]);
            chk($sformatf("%s_c%0d", name, i), oq_c[i], pc[i]);
        end
        if (oq_d.size() >= 6)
            chk({name, "_csum_full"}, oq_d[4][63:48], full_csum(oq_d[2], oq_d[3], oq_d[4], oq_d[5]));
        oq_d.delete();
        oq_c.delete();
    endtask

    task automatic load_udp();
        pd[0] = 64'h0000_0007_0040_0001; pc[0] = 8'hFF;
        pd[1] = 64'h0011_2233_4455_6677; pc[1] = 8'h00;
        pd[2] = 64'h8899_aabb_0800_4500; pc[2] = 8'h00;
        pd[3] = 64'h0073_0000_4000_4011; pc[3] = 8'h00;
        pd[4] = 64'hb861_c0a8_0001_c0a8; pc[4] = 8'h00;
        pd[5] = 64'h00c7_0400_0035_005f; pc[5] = 8'h00;
        pd[6] = 64'habcd_0102_0304_0506; pc[6] = 8'h01;
        for (int i = 0; i < 7; i++) ed[i] = pd[i];
    endtask

    initial begin
        reset = 1'b1; act_valid = 1'b0; act_mask = '0;
        act_dl_dst = 48'ha1a2_a3a4_a5a6; act_dl_src = 48'hb1b2_b3b4_b5b6;
        act_nw_src = 32'hc0a8_0002; act_nw_dst = 32'h0a00_0002; act_nw_tos = 8'h10;
        act_tp_src = 16'h1234; act_tp_dst = 16'h5678;
        in_if.wr = 1'b0; in_if.data = '0; in_if.ctrl = '0;
        repeat (3) @(negedge clk);
        chk("rst_out_wr", out_if.wr, 0);
        chk("rst_out_data", out_if.data, 0);
        chk("rst_out_ctrl", out_if.ctrl, 0);
        chk("rst_pkts", pkts_modified, 0);
        chk("rst_act_rdy", act_rdy, 1);
        chk("rst_in_rdy", in_if.rdy, 0);
        reset = 1'b0;
        @(negedge clk);

        // nw_src only: checksum b861 -> b860
        load_udp();
        ed[4] = 64'hb860_c0a8_0002_c0a8;
        give_act(8'h04); send_range(0, 6); check_out("nwsrc");
        chk("nwsrc_pkts", pkts_modified, 1);

        // every field
        load_udp();
        act_nw_src = 32'h0a00_0001;
        ed[1] = 64'ha1a2_a3a4_a5a6_b1b2;
        ed[2] = 64'hb3b4_b5b6_0800_4510;
        ed[4] = 64'h2668_0a00_0001_0a00;
        ed[5] = 64'h0002_1234_5678_005f;
        give_act(8'h7F); send_range(0, 6); check_out("all");
        chk("all_pkts", pkts_modified, 2);

        // ARP: only MACs change
        pd[0] = 64'h0000_0007_0040_0001; pc[0] = 8'hFF;
        pd[1] = 64'hffff_ffff_ffff_6677; pc[1] = 8'h00;
        pd[2] = 64'h8899_aabb_0806_0001; pc[2] = 8'h00;
        pd[3] = 64'h0800_0604_0001_8899; pc[3] = 8'h00;
        pd[4] = 64'haabb_c0a8_0001_0000; pc[4] = 8'h00;
        pd[5] = 64'h0000_0000_c0a8_0002; pc[5] = 8'h00;
        pd[6] = 64'h0000_0000_0000_0000; pc[6] = 8'h01;
        for (int i = 0; i < 7; i++) ed[i] = pd[i];
        ed[1] = 64'ha1a2_a3a4_a5a6_b1b2;
        ed[2] = 64'hb3b4_b5b6_0806_0001;
        give_act(8'h1F); send_range(0, 6);
        repeat (12) @(negedge clk);
        chk("arp_count", oq_d.size(), 7);
        for (int i = 0; i < 7 && i < oq_d.size(); i++)
            chk($sformatf("arp_w%0d", i), oq_d[i], ed[i]);
        oq_d.delete(); oq_c.delete();
        chk("arp_pkts", pkts_modified, 3);

        // IHL=6: ports stay
        load_udp();
        pd[2] = 64'h8899_aabb_0800_4600; ed[2] = pd[2];
        give_act(8'h60); send_range(0, 6);
        repeat (12) @(negedge clk);
        chk("ihl6_count", oq_d.size(), 7);
        if (oq_d.size() == 7) chk("ihl6_w5", oq_d[5], pd[5]);
        oq_d.delete(); oq_c.delete();
        chk("ihl6_pkts", pkts_modified, 3);

        // fragment offset 1: ports stay
        load_udp();
        pd[3] = 64'h0073_0000_4001_4011; ed[3] = pd[3];
        give_act(8'h60); send_range(0, 6);
        repeat (12) @(negedge clk);
        chk("frag_count", oq_d.size(), 7);
        if (oq_d.size() == 7) chk("frag_w5", oq_d[5], pd[5]);
        oq_d.delete(); oq_c.delete();
        chk("frag_pkts", pkts_modified, 3);

        // backpressure toggling + late action; nw_dst only
        load_udp();
        act_nw_dst = 32'hc0a8_00c8;
        ed[4] = 64'hb860_c0a8_0001_c0a8;
        ed[5] = 64'h00c8_0400_0035_005f;
        tog_en = 1'b1;
        fork
            begin
                for (int k = 0; k < 5; k++) begin
                    #1 chk($sformatf("wait_in_rdy%0d", k), in_if.rdy, 0);
                    @(negedge clk);
                end
                give_act(8'h08);
            end
            send_range(0, 6);
        join
        check_out("bp");
        tog_en = 1'b0;
        chk("bp_pkts", pkts_modified, 4);

        // reset while W2 is expected
        load_udp();
        act_nw_src = 32'hc0a8_0002;
        give_act(8'h04); send_range(0, 2);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_out_wr", out_if.wr, 0);
        chk("midrst_act_rdy", act_rdy, 1);
        reset = 1'b0;
        chk("midrst_pkts", pkts_modified, 0);
        @(negedge clk);
        oq_d.delete(); oq_c.delete();
        ed[4] = 64'hb860_c0a8_0002_c0a8;
        give_act(8'h04); send_range(0, 5);
        chk("post_rst_pkts_pre_eop", pkts_modified, 0);
        send_range(6, 6);
        check_out("post_rst");
        chk("post_rst_pkts", pkts_modified, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule

// File: doc/header_rewriter.md
Name: header_rewriter

Overview:
- Inline 64-bit NetFPGA packet-stream stage, placed after the lookup and action stages and before the output queues.
- Applies one per-packet OpenFlow modify-field action: dl_dst, dl_src, nw_src, nw_dst, nw_tos, tp_src, tp_dst.
- It is the writer counterpart of the header parser: it writes the same fields back into the same word positions.
- Updates the IPv4 header checksum incrementally. L4 checksums are not updated.

Parameters:
DATA_WIDTH, 64, stream data width; only 64 is supported.
CTRL_WIDTH, DATA_WIDTH/8, stream ctrl width.
IOQ_CTRL, 8'hFF, ctrl value marking module-header words.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
in_data  in  64  packet word
in_ctrl  in  8  0 = data word; nonzero = module header, or EOP after the first data word
in_wr  in  1  word valid; legal only while in_rdy=1
in_rdy  out  1  ready to accept a word
out_data  out  64  registered output word
out_ctrl  out  8  registered output ctrl
out_wr  out  1  output word valid
out_rdy  in  1  downstream can accept; downstream guarantees one word of slack
act_valid  in  1  action available for the next packet
act_rdy  out  1  action accepted this cycle when act_valid=1
act_mask  in  8  enables: [0] dl_dst, [1] dl_src, [2] nw_src, [3] nw_dst, [4] nw_tos, [5] tp_src, [6] tp_dst; [7] reserved, ignored
act_dl_dst  in  48  new destination MAC
act_dl_src  in  48  new source MAC
act_nw_src  in  32  new IPv4 source
act_nw_dst  in  32  new IPv4 destination
act_nw_tos  in  8  new TOS
act_tp_src  in  16  new L4 source port
act_tp_dst  in  16  new L4 destination port
pkts_modified  out  32  count of packets in which at least one field was rewritten

Behaviour:
- Reset (synchronous, active-high):
  - out_wr=0, out_data=0, out_ctrl=0, pkts_modified=0, latched action cleared, state=WAIT_ACT.
  - Reset mid-packet abandons the packet; downstream sees it truncated.
- Handshakes:
  - act_rdy=1 only in WAIT_ACT. An action handshake latches all act_* inputs and moves to MOD_HDR.
  - in_rdy = out_rdy && state not in {WAIT_ACT, DRAIN}.
  - An accepted word produces out_wr=1 on the next cycle (latency 1), except when held in W3.
- States (advance only on accepted words):
  - MOD_HDR: words with ctrl≠0 pass through unchanged; the first ctrl==0 word is W0.
  - W0: bit0 → [63:16]=dl_dst; bit1 → [15:0]=dl_src[47:32].
  - W1: bit1 → [63:32]=dl_src[31:0].
    - is_ip = ([31:16]==16'h0800 && [15:12]==4).
    - If is_ip, capture IHL=[11:8] and old {ver/IHL,tos}; bit4 → [7:0]=tos.
  - W2: capture proto=[7:0]; nofrag = ([28:16]==0 && [29]==0).
  - W3: if is_ip, bit2 → [47:16]=nw_src; bit3 → [15:0]=nw_dst[31:16]. The word is held, not emitted.
  - W4:
    - Emit held W3 with checksum [63:48] replaced by HC'.
    - Hold W4: bit3 → [63:48]=nw_dst[15:0].
    - If is_ip && IHL==5 && nofrag && proto∈{6,17}: bit5 → [47:32]=tp_src; bit6 → [31:16]=tp_dst.
    - Go to DRAIN.
  - DRAIN: in_rdy=0; emit held W4 when out_rdy=1, then PAYLOAD.
  - PAYLOAD: pass words unchanged.
- EOP: ctrl≠0 accepted in any W* or PAYLOAD state.
  - The word is still rewritten per its position; the packet ends.
  - If a held W3 exists, it is emitted first with the checksum unchanged, then the EOP word. Both are stall-correct via DRAIN.
  - Return to WAIT_ACT.
- Checksum (RFC 1624, HC' = ~(~HC + Σ~m + Σm')):
  - Terms are the 16-bit words actually changed: {ver/IHL,tos}, nw_src hi/lo, nw_dst hi/lo.
  - 20-bit accumulate, then two end-around-carry folds to 16 bits.
  - Unmasked fields contribute nothing. Non-IP packets: no IP/TP edits, no checksum change.
- pkts_modified:
  - Increments by 1 at EOP when at least one word was actually altered by an enabled field.
  - Wraps from 0xFFFFFFFF to 0.
- Runts ending before W4: no TP edits, checksum untouched; already-emitted words stand.

Test Plan:
- IPv4 UDP, IHL=5, header 4500 0073 0000 4000 4011 b861 c0a8 0001 c0a8 00c7, mask=0x04, nw_src=c0a80002 → W3 [47:16]=c0a80002, checksum b860, other bytes identical, pkts_modified=1.
- Same packet, mask=0x7F, all fields set, tp_src=0x1234, tp_dst=0x5678 → every field replaced at the positions above; checksum equals a full recompute; L4 checksum unchanged.
- ARP (ethertype 0806), mask=0x1F → only MACs rewritten; W1 [7:0] and all later words bit-identical.
- IHL=6, or frag offset=1, with mask=0x60 → ports unchanged, pkts_modified unchanged.
- out_rdy toggled 1/0 every cycle and act_valid delayed 5 cycles → no word lost or duplicated; output order equals input order; in_rdy=0 in WAIT_ACT and DRAIN.
- Reset asserted at W2 → next cycle out_wr=0, act_rdy=1; the following packet is processed correctly with pkts_modified=0 before its EOP.
